// File: rtl/nes_bus_pkg.sv
// Shared CPU bus decode constants and OAM DMA state type for the NES memory responder.
package nes_bus_pkg;

  localparam logic [15:0] WRAM_BASE     = 16'h0000;
  localparam logic [15:0] WRAM_LIMIT    = 16'h1FFF;
  localparam logic [15:0] PRG_RAM_BASE  = 16'h6000;
  localparam logic [15:0] PRG_RAM_LIMIT = 16'h7FFF;
  localparam logic [15:0] OAMDMA_ADDR   = 16'h4014;
  localparam logic [15:0] PRG_ROM_BASE  = 16'h8000;
  localparam logic [15:0] PRG_ROM_LIMIT = 16'hFFFF;

  localparam logic [7:0]  OPEN_BUS      = 8'h00;

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, RD, WR} dma_state_t;

  // Regions are power-of-two aligned, so base^limit is the offset mask.
  function automatic logic in_range(input logic [15:0] a, input logic [15:0] base,
                                    input logic [15:0] limit);
    return (a & ~(base ^ limit)) == base;
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: stalls the CPU, walks a 256-byte page and emits one OAM write per byte.
module oam_dma_engine
  import nes_bus_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_page,
  input  logic [7:0]  i_rd_data,
  output logic [15:0] o_rd_addr,
  output logic        o_cpu_rdy,
  output logic        o_oam_we,
  output logic [7:0]  o_oam_wdata
);

  dma_state_t r_state;
  logic       r_parity;
  logic [7:0] r_page;
  logic [7:0] r_index;

  assign o_rd_addr = {r_page, r_index};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_parity    <= 1'b0;
      r_page      <= '0;
      r_index     <= '0;
      o_cpu_rdy   <= 1'b1;
      o_oam_we    <= 1'b0;
      o_oam_wdata <= OPEN_BUS;
    end else begin
      r_parity <= ~r_parity;
      o_oam_we <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_page    <= i_page;
            r_index   <= '0;
            o_cpu_rdy <= 1'b0;
            r_state   <= HALT;
          end
        end
        HALT:  r_state <= r_parity ? ALIGN : RD;
        ALIGN: r_state <= RD;
        RD: begin
          o_oam_we    <= 1'b1;
          o_oam_wdata <= i_rd_data;
          r_state     <= WR;
        end
        WR: begin
          r_index <= r_index + 8'd1;
          if (r_index == 8'hFF) begin
            o_cpu_rdy <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_state <= RD;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// CPU bus responder: mirrored WRAM, loadable PRG ROM, open bus and OAM DMA at $4014.
// Optional PRG_RAM_EN maps 8 KB RAM at $6000-$7FFF.
module cpu_mem_responder
  import nes_bus_pkg::*;
#(
  parameter int PRG_AW  = 15,
  parameter int WRAM_AW = 11
) (
  input  logic              clk_ph2,
  input  logic              rst,
  input  logic [15:0]       Addr_bus,
  input  logic [7:0]        Data_bus_out,
  input  logic              R_nW,
  output logic [7:0]        Data_bus_in,
  output logic              cpu_rdy,
  input  logic              ld_we,
  input  logic [PRG_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              oam_we,
  output logic [7:0]        oam_wdata
);

  logic [7:0]  r_wram [2**WRAM_AW];
  logic [7:0]  r_rom  [2**PRG_AW];
`ifdef PRG_RAM_EN
  logic [7:0]  r_prg_ram [8192];
`endif
  logic [7:0]  r_open_bus;

  logic [15:0] w_dma_addr;
  logic [15:0] w_addr;
  logic        w_hit;
  logic [7:0]  w_rd_data;
  logic        w_cpu_wr;
  logic        w_dma_start;

  // DMA owns the decode while the CPU is stalled.
  assign w_addr      = cpu_rdy ? Addr_bus : w_dma_addr;
  assign w_cpu_wr    = cpu_rdy & ~R_nW;
  assign w_dma_start = w_cpu_wr && (Addr_bus == OAMDMA_ADDR);

  always_comb begin
    w_hit     = 1'b0;
    w_rd_data = r_open_bus;
    if (in_range(w_addr, WRAM_BASE, WRAM_LIMIT)) begin
      w_hit     = 1'b1;
      w_rd_data = r_wram[w_addr[WRAM_AW-1:0]];
    end else if (in_range(w_addr, PRG_ROM_BASE, PRG_ROM_LIMIT)) begin
      w_hit     = 1'b1;
      w_rd_data = r_rom[w_addr[PRG_AW-1:0]];
    end else if (in_range(w_addr, PRG_RAM_BASE, PRG_RAM_LIMIT)) begin
`ifdef PRG_RAM_EN
      w_hit     = 1'b1;
      w_rd_data = r_prg_ram[w_addr[12:0]];
`else
      w_hit     = 1'b0;
`endif
    end
  end

  assign Data_bus_in = cpu_rdy ? w_rd_data : r_open_bus;

  always_ff @(posedge clk_ph2) begin
    if (rst) begin
      r_open_bus <= OPEN_BUS;
    end else if (cpu_rdy && R_nW && w_hit) begin
      r_open_bus <= w_rd_data;
    end
  end

  always_ff @(posedge clk_ph2) begin
    if (w_cpu_wr && in_range(Addr_bus, WRAM_BASE, WRAM_LIMIT)) begin
      r_wram[Addr_bus[WRAM_AW-1:0]] <= Data_bus_out;
    end
    if (ld_we) begin
      r_rom[ld_addr] <= ld_data;
    end
`ifdef PRG_RAM_EN
    if (w_cpu_wr && in_range(Addr_bus, PRG_RAM_BASE, PRG_RAM_LIMIT)) begin
      r_prg_ram[Addr_bus[12:0]] <= Data_bus_out;
    end
`endif
  end

  oam_dma_engine u_dma (
    .i_clk       (clk_ph2),
    .i_rst       (rst),
    .i_start     (w_dma_start),
    .i_page      (Data_bus_out),
    .i_rd_data   (w_rd_data),
    .o_rd_addr   (w_dma_addr),
    .o_cpu_rdy   (cpu_rdy),
    .o_oam_we    (oam_we),
    .o_oam_wdata (oam_wdata)
  );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder against a flat memory-map reference model.
`timescale 1ns/1ps
module tb_cpu_mem_responder;

  localparam logic [15:0] IDLE_ADDR = 16'h3000;

  logic        clk_ph2      = 1'b0;
  logic        rst          = 1'b1;
  logic [15:0] Addr_bus     = IDLE_ADDR;
  logic [7:0]  Data_bus_out = '0;
  logic        R_nW         = 1'b1;
  logic        ld_we        = 1'b0;
  logic [14:0] ld_addr      = '0;
  logic [7:0]  ld_data      = '0;
  logic [7:0]  Data_bus_in, oam_wdata, d14_data_in, d14_oam_wdata;
  logic        cpu_rdy, oam_we, d14_cpu_rdy, d14_oam_we;

  always #5 clk_ph2 = ~clk_ph2;

  cpu_mem_responder #(.PRG_AW(15), .WRAM_AW(11)) u_dut (
    .clk_ph2(clk_ph2), .rst(rst), .Addr_bus(Addr_bus), .Data_bus_out(Data_bus_out),
    .R_nW(R_nW), .Data_bus_in(Data_bus_in), .cpu_rdy(cpu_rdy), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data), .oam_we(oam_we), .oam_wdata(oam_wdata)
  );

  cpu_mem_responder #(.PRG_AW(14), .WRAM_AW(11)) u_dut14 (
    .clk_ph2(clk_ph2), .rst(rst), .Addr_bus(Addr_bus), .Data_bus_out(Data_bus_out),
    .R_nW(R_nW), .Data_bus_in(d14_data_in), .cpu_rdy(d14_cpu_rdy), .ld_we(ld_we),
    .ld_addr(ld_addr[13:0]), .ld_data(ld_data), .oam_we(d14_oam_we), .oam_wdata(d14_oam_wdata)
  );

  // Reference model: flat arrays plus the open-bus latch.
  logic [7:0] m_wram [2048];
  logic [7:0] m_rom  [32768];
  logic [7:0] m_prg  [8192];
  logic [7:0] m_latch = 8'h00;

  logic [7:0]  rd_q [$];
  logic [7:0]  oam_q [$];
  bit          chk_rd = 1'b0;
  int          oam_pulses = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned k_par = 0;

  always @(posedge clk_ph2) k_par <= rst ? 0 : k_par + 1;

  function automatic bit decoded(input int unsigned a);
    if (a < 'h2000 || a >= 'h8000) return 1'b1;
`ifdef PRG_RAM_EN
    if (a >= 'h6000) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [7:0] mem_val(input int unsigned a);
    if (a < 'h2000) return m_wram[a % 2048];
    if (a >= 'h8000) return m_rom[a % 32768];
    return m_prg[a % 8192];
  endfunction

  function automatic logic [7:0] bus_val(input int unsigned a);
    return decoded(a) ? mem_val(a) : m_latch;
  endfunction

  function automatic void model_write(input int unsigned a, input logic [7:0] d);
    if (a < 'h2000) m_wram[a % 2048] = d;
`ifdef PRG_RAM_EN
    else if (a >= 'h6000 && a < 'h8000) m_prg[a % 8192] = d;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read or an OAM write.
  always @(negedge clk_ph2) begin
    if (chk_rd) begin
      if (rd_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL cpu_read_unexpected: got 0x%0h expected nothing queued", Data_bus_in);
      end else begin
        check("cpu_read", {24'h0, Data_bus_in}, {24'h0, rd_q.pop_front()});
      end
    end
    if (oam_we) begin
      oam_pulses++;
      if (oam_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL oam_extra: got 0x%0h expected no pulse", oam_wdata);
      end else begin
        check("oam_data", {24'h0, oam_wdata}, {24'h0, oam_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk_ph2);
    #1;
  endtask

  task automatic cpu_read(input int unsigned a);
    Addr_bus = a[15:0];
    R_nW     = 1'b1;
    rd_q.push_back(bus_val(a));
    if (decoded(a)) m_latch = mem_val(a);
    chk_rd = 1'b1;
    tick();
    chk_rd   = 1'b0;
    Addr_bus = IDLE_ADDR;
  endtask

  task automatic cpu_write(input int unsigned a, input logic [7:0] d);
    Addr_bus     = a[15:0];
    Data_bus_out = d;
    R_nW         = 1'b0;
    model_write(a, d);
    tick();
    R_nW     = 1'b1;
    Addr_bus = IDLE_ADDR;
  endtask

  task automatic rom_load(input int unsigned idx, input logic [7:0] d);
    ld_we   = 1'b1;
    ld_addr = idx[14:0];
    ld_data = d;
    m_rom[idx % 32768] = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic dma_start(input logic [7:0] page, input bit odd);
    if (((k_par + 1) % 2) != odd) tick();
    for (int i = 0; i < 256; i++) oam_q.push_back(bus_val({page, i[7:0]}));
    cpu_write(16'h4014, page);
  endtask

  task automatic dma_run(input logic [7:0] page, input bit odd);
    int low;
    int first;
    int p0;
    low   = 0;
    first = 0;
    p0    = oam_pulses;
    dma_start(page, odd);
    // A CPU write attempted during DMA must be ignored.
    Addr_bus     = 16'h0005;
    Data_bus_out = 8'hEE;
    R_nW         = 1'b0;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk_ph2);
      if (oam_we && first == 0) first = n;
      if (cpu_rdy) break;
      low++;
      if (n == 50) check("dma_bus_hold", {24'h0, Data_bus_in}, {24'h0, m_latch});
    end
    R_nW     = 1'b1;
    Addr_bus = IDLE_ADDR;
    tick();
    check("dma_rdy_low", low, 513 + int'(odd));
    check("dma_first_we", first, 3 + int'(odd));
    check("dma_pulses", oam_pulses - p0, 256);
    check("dma_queue_drained", oam_q.size(), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int p0;
    int unsigned op;
    int unsigned a;
    logic [7:0] exp_last;

    // Reset state
    tick(); tick();
    check("rst_cpu_rdy", {31'h0, cpu_rdy}, 1);
    check("rst_oam_we", {31'h0, oam_we}, 0);
    check("rst_oam_wdata", {24'h0, oam_wdata}, 0);
    check("rst_open_bus", {24'h0, Data_bus_in}, 0);
    rst = 1'b0;

    // ROM load and mirroring
    rom_load(0, 8'hA2);
    rom_load(1, 8'hFD);
    for (int i = 2; i < 16; i++) rom_load(i, 8'($urandom));
    cpu_read(16'h8000);
    cpu_read(16'h8001);
    Addr_bus = 16'hC001;
    @(negedge clk_ph2);
    check("rom14_mirror", {24'h0, d14_data_in}, 32'hFD);
    check("rom14_rdy", {31'h0, d14_cpu_rdy}, 1);
    tick();
    cpu_read(16'h8000);

    // WRAM init: page 2 holds i^5A for DMA
    for (int i = 0; i < 2048; i++)
      cpu_write(i, (i / 256 == 2) ? (8'(i % 256) ^ 8'h5A) : 8'($urandom));
`ifdef PRG_RAM_EN
    for (int i = 0; i < 8192; i++) cpu_write('h6000 + i, 8'($urandom));
`endif

    cpu_write(16'h0005, 8'h3C);
    cpu_read(16'h0805);
    cpu_read(16'h1005);
    cpu_read(16'h1805);
    cpu_read(16'h2000);

    cpu_write(16'h6123, 8'h77);
    cpu_read(16'h6123);
    cpu_read(16'h0005);
    cpu_read(16'h6123);

    // OAM DMA: even and odd parity, open-bus page
    dma_run(8'h02, 1'b0);
    dma_run(8'h02, 1'b1);
    cpu_read(16'h0006);
    dma_run(8'h45, 1'b0);

    // Reset in the middle of a DMA
    p0 = oam_pulses;
    dma_start(8'h02, 1'b1);
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_ph2);
      if (oam_we) cnt++;
      if (cnt == 10) break;
    end
    rst = 1'b1;
    m_latch = 8'h00;
    tick();
    @(negedge clk_ph2);
    check("abort_cpu_rdy", {31'h0, cpu_rdy}, 1);
    check("abort_oam_we", {31'h0, oam_we}, 0);
    tick();
    rst = 1'b0;
    oam_q.delete();
    repeat (600) tick();
    check("abort_pulses", oam_pulses - p0, 10);
    dma_run(8'h02, 1'b0);
    exp_last = mem_val(16'h02FF);
    check("last_oam_wdata", {24'h0, oam_wdata}, {24'h0, exp_last});
    check("d14_last_oam_wdata", {24'h0, d14_oam_wdata}, {24'h0, exp_last});
    check("d14_idle", {30'h0, d14_cpu_rdy, d14_oam_we}, 32'h2);
    cpu_read(16'h0005);

    // Randomized bus traffic
    for (int t = 0; t < 300; t++) begin
      op = $urandom_range(0, 4);
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 'h1FFF);
        1:       a = 'h8000 + $urandom_range(0, 15);
        2:       a = 'h2000 + $urandom_range(0, 'h3FFF);
        default: a = 'h6000 + $urandom_range(0, 'h1FFF);
      endcase
      if (a == 'h4014) a = 'h4015;
      if (op <= 1) cpu_read(a);
      else if (op <= 3) cpu_write(a, 8'($urandom));
      else rom_load($urandom_range(0, 15), 8'($urandom));
    end
    tick();
    check("read_queue_drained", rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
